clk_div_monitor: RTL

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_pkg.sv | 30 +++
 rtl/clk_dual_edge_sampler.sv | 49 ++++
 rtl/clk_div_monitor.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the divided-clock monitor: FSM state encoding, the
// half-cycle counter ceiling, and a saturating adder used by both counters.
// -----------------------------------------------------------------------------
package clk_div_pkg;

  // Monitor FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  // Half-cycle counters stop here; reaching it while tracking means a stall
  localparam logic [7:0] HC_MAX = 8'd255;

  // Add 0..3 to an 8-bit count, clamping at HC_MAX
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    if (sum > {1'b0, HC_MAX}) begin
      sat_add = HC_MAX;
    end else begin
      sat_add = sum[7:0];
    end
  endfunction

endpackage

// File: rtl/clk_dual_edge_sampler.sv
// -----------------------------------------------------------------------------
// clk_dual_edge_sampler
// Samples div_clk on both edges of clk and presents, at each posedge, the
// ordered pair of half-cycle samples for the clk period just finished plus the
// last sample of the previous period (needed for edge detection across the
// period boundary). div_clk is derived from clk, so no synchronizer is used.
//
// Ports:
//   clk     in  reference clock
//   rstn    in  asynchronous active-low reset (both sample flops)
//   div_clk in  divided clock under test
//   x_prev  out posedge sample from the previous clk period
//   x_pair  out [0] = negedge sample (earlier), [1] = posedge sample (later)
// -----------------------------------------------------------------------------
module clk_dual_edge_sampler (
  input  logic       clk,
  input  logic       rstn,
  input  logic       div_clk,
  output logic       x_prev,
  output logic [1:0] x_pair
);

  logic neg_r;
  logic pos_r;

  // Negedge sample: first half-cycle sample of each clk period
  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      neg_r <= 1'b0;
    end else begin
      neg_r <= div_clk;
    end
  end

  // Posedge sample, held so the next period can see the boundary transition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_r <= 1'b0;
    end else begin
      pos_r <= div_clk;
    end
  end

  // The posedge sample of the current period is div_clk as seen by the
  // consuming posedge flops, which capture it at this same edge.
  assign x_prev = pos_r;
  assign x_pair = {div_clk, neg_r};

endmodule

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
// Measures period and high time of a clk-derived divided clock with half-cycle
// resolution, compares each completed period against EXP_DIV and tracks lock.
//
// Ports:
//   clk        in   reference clock
//   rstn       in   asynchronous active-low reset
//   div_clk    in   divided clock under test
//   period_hc  out  last measured period, clk half-cycles
//   high_hc    out  last measured high time, clk half-cycles
//   meas_valid out  one-cycle pulse when period_hc/high_hc update
//   err        out  one-cycle pulse for a completed period that mismatches
//   stall      out  one-cycle pulse when no rising edge for 255 half-cycles
//   lock       out  high while the ratio is continuously correct
//   err_cnt    out  saturating count of err pulses
// -----------------------------------------------------------------------------
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int EXP_DIV  = 5,
  parameter int LOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       div_clk,
  output logic [7:0] period_hc,
  output logic [7:0] high_hc,
  output logic       meas_valid,
  output logic       err,
  output logic       stall,
  output logic       lock,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] EXP_PERIOD = 8'(2 * EXP_DIV);
  localparam logic [7:0] EXP_HIGH   = 8'(EXP_DIV);
  localparam logic [7:0] LOCK_TGT   = 8'(LOCK_CNT);

  logic       x_prev_s;
  logic [1:0] x_pair_s;

  clk_dual_edge_sampler u_sampler (
    .clk     (clk),
    .rstn    (rstn),
    .div_clk (div_clk),
    .x_prev  (x_prev_s),
    .x_pair  (x_pair_s)
  );

  state_e     state_r, state_nxt_s;
  logic [7:0] pcnt_r, pcnt_nxt_s;
  logic [7:0] hcnt_r, hcnt_nxt_s;
  logic [7:0] run_r, run_nxt_s;
  logic [7:0] period_hc_r, high_hc_r, err_cnt_r;
  logic       meas_valid_r, err_r, stall_r, lock_r;

  logic       rise_a_s, rise_b_s, rise_s, good_s;
  logic       meas_s, err_s, stall_s;
  logic [1:0] high_inc_s;
  logic [7:0] close_p_s, close_h_s, start_p_s, start_h_s;
  logic [7:0] pcnt_add_s, hcnt_add_s, run_inc_s;

  // Edge detection and closing/opening period arithmetic
  always_comb begin
    rise_a_s   = ~x_prev_s & x_pair_s[0];
    rise_b_s   = ~x_pair_s[0] & x_pair_s[1];
    // A rise on the first sample needs x_pair[0]=1 and one on the second needs
    // x_pair[0]=0, so a double rise cannot occur within one clk period; any
    // such waveform would still be judged by good_s below.
    rise_s     = rise_a_s | rise_b_s;
    high_inc_s = {1'b0, x_pair_s[0]} + {1'b0, x_pair_s[1]};
    pcnt_add_s = sat_add(pcnt_r, 2'd2);
    hcnt_add_s = sat_add(hcnt_r, high_inc_s);
    run_inc_s  = run_r + 8'd1;
    if (rise_a_s) begin
      // The rising sample opens the new period, so the old one ends at pcnt_r
      close_p_s = pcnt_r;
      close_h_s = hcnt_r;
      start_p_s = 8'd2;
      start_h_s = 8'd1 + {7'd0, x_pair_s[1]};
    end else begin
      // The negedge sample still belongs to the closing period
      close_p_s = sat_add(pcnt_r, 2'd1);
      close_h_s = sat_add(hcnt_r, {1'b0, x_pair_s[0]});
      start_p_s = 8'd1;
      start_h_s = 8'd1;
    end
    good_s = (close_p_s == EXP_PERIOD) && (close_h_s == EXP_HIGH);
  end

  // Next-state logic, counter updates and per-cycle event strobes
  always_comb begin
    state_nxt_s = state_r;
    pcnt_nxt_s  = pcnt_r;
    hcnt_nxt_s  = hcnt_r;
    run_nxt_s   = run_r;
    meas_s      = 1'b0;
    err_s       = 1'b0;
    stall_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Anything before the first rising edge is a partial period: drop it
        if (rise_s) begin
          state_nxt_s = ST_MEASURE;
          pcnt_nxt_s  = start_p_s;
          hcnt_nxt_s  = start_h_s;
        end else begin
          pcnt_nxt_s  = 8'd0;
          hcnt_nxt_s  = 8'd0;
        end
        run_nxt_s = 8'd0;
      end
      ST_MEASURE, ST_CHECK, ST_LOCKED: begin
        if (rise_s) begin
          meas_s     = 1'b1;
          pcnt_nxt_s = start_p_s;
          hcnt_nxt_s = start_h_s;
          if (!good_s) begin
            err_s       = 1'b1;
            run_nxt_s   = 8'd0;
            state_nxt_s = ST_CHECK;
          end else if (state_r == ST_LOCKED) begin
            state_nxt_s = ST_LOCKED;
          end else if (run_inc_s >= LOCK_TGT) begin
            run_nxt_s   = run_inc_s;
            state_nxt_s = ST_LOCKED;
          end else begin
            run_nxt_s   = run_inc_s;
            state_nxt_s = ST_CHECK;
          end
        end else if (pcnt_add_s == HC_MAX) begin
          // Edges have stopped; restart acquisition from scratch
          stall_s     = 1'b1;
          state_nxt_s = ST_IDLE;
          pcnt_nxt_s  = 8'd0;
          hcnt_nxt_s  = 8'd0;
          run_nxt_s   = 8'd0;
        end else begin
          pcnt_nxt_s = pcnt_add_s;
          hcnt_nxt_s = hcnt_add_s;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pcnt_nxt_s  = 8'd0;
        hcnt_nxt_s  = 8'd0;
        run_nxt_s   = 8'd0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      pcnt_r       <= 8'd0;
      hcnt_r       <= 8'd0;
      run_r        <= 8'd0;
      period_hc_r  <= 8'd0;
      high_hc_r    <= 8'd0;
      err_cnt_r    <= 8'd0;
      meas_valid_r <= 1'b0;
      err_r        <= 1'b0;
      stall_r      <= 1'b0;
      lock_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pcnt_r       <= pcnt_nxt_s;
      hcnt_r       <= hcnt_nxt_s;
      run_r        <= run_nxt_s;
      meas_valid_r <= meas_s;
      err_r        <= err_s;
      stall_r      <= stall_s;
      // Derived from next state so lock falls with the err/stall pulse
      lock_r       <= (state_nxt_s == ST_LOCKED);
      if (meas_s) begin
        period_hc_r <= close_p_s;
        high_hc_r   <= close_h_s;
      end
      if (err_s && (err_cnt_r != HC_MAX)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  assign period_hc  = period_hc_r;
  assign high_hc    = high_hc_r;
  assign meas_valid = meas_valid_r;
  assign err        = err_r;
  assign stall      = stall_r;
  assign lock       = lock_r;
  assign err_cnt    = err_cnt_r;

endmodule
